// File: rtl/note_lane_vga.sv
// note_lane_vga: falling-note lane renderer for the VGA path.
// Each lane scrolls a column of note cells downward once per PERIOD pixel
// clocks. Presses are latched between steps, so a one-cycle press is never lost.
// Pixels are painted in this order: note cell, then hit bar, then the
// octave-tinted gradient background.
module note_lane_vga #(
  parameter int          LANES         = 7,
  parameter int          X0            = 112,
  parameter int          LANE_PITCH    = 64,
  parameter int          LANE_W        = 32,
  parameter int          Y0            = 0,
  parameter int          ROWS          = 96,
  parameter int          CELL_SHIFT    = 2,
  parameter int          HIT_Y         = 400,
  parameter int          HIT_H         = 16,
  parameter int          PERIOD        = 100000,
  parameter logic [23:0] BLOCK_COLOR   = 24'h000000,
  parameter logic [23:0] HIT_ON_COLOR  = 24'hFFD700,
  parameter logic [23:0] HIT_OFF_COLOR = 24'h808080
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [LANES-1:0] note,
  input  logic [1:0]       shift,
  input  logic             pause,
  input  logic             clear,
  output logic [23:0]      pos_data,
  output logic             step,
  output logic [LANES-1:0] hit_lanes
);

  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [10:0] FIELD_LO = 11'(Y0);
  localparam logic [10:0] FIELD_HI = 11'(Y0 + (ROWS << CELL_SHIFT));
  localparam logic [10:0] HIT_LO   = 11'(HIT_Y);
  localparam logic [10:0] HIT_HI   = 11'(HIT_Y + HIT_H);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        step_q, step_d;
  logic [LANES-1:0]            cap_q, cap_d;
  logic [LANES-1:0][ROWS-1:0]  rows_q, rows_d;
  logic [23:0]                 pos_data_q, pos_data_d;

  logic        step_fire;
  logic [10:0] x11, y11;
  logic        in_field, in_hit;
  logic [ROW_W-1:0] row;
  logic [7:0]  g;
  logic [23:0] bg;

  assign step_fire = !pause && (cnt_q == CNT_W'(PERIOD - 1));

  // Scroll control: count, capture presses, shift lanes on the step edge; clear wins.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    cap_d  = cap_q | note;
    rows_d = rows_q;
    if (clear) begin
      cnt_d  = '0;
      cap_d  = '0;
      rows_d = '0;
    end else if (step_fire) begin
      cnt_d  = '0;
      step_d = 1'b1;
      cap_d  = '0;
      for (int i = 0; i < LANES; i++) begin
        rows_d[i] = {rows_q[i][ROWS-2:0], cap_q[i] | note[i]};
      end
    end else if (!pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Geometry is compared at 11 bits so lane/field bounds past 1023 cannot wrap.
  assign x11      = {1'b0, pos_x};
  assign y11      = {1'b0, pos_y};
  assign in_field = (y11 >= FIELD_LO) && (y11 < FIELD_HI);
  assign in_hit   = (y11 >= HIT_LO) && (y11 < HIT_HI);
  assign row      = ROW_W'((y11 - FIELD_LO) >> CELL_SHIFT);
  assign g        = pos_y[8:1];

  // Background tint follows the octave select.
  always_comb begin
    case (shift)
      2'b10:   bg = {g, g, 8'hFF};
      2'b01:   bg = {8'hFF, g, g};
      default: bg = 24'hFFFFFF;
    endcase
  end

  // Pixel colour: first matching lane (lowest index) decides cell / hit bar.
  always_comb begin
    logic found;
    found      = 1'b0;
    pos_data_d = bg;
    for (int i = 0; i < LANES; i++) begin
      if (!found && (x11 >= 11'(X0 + i * LANE_PITCH)) &&
          (x11 < 11'(X0 + i * LANE_PITCH + LANE_W))) begin
        found = 1'b1;
        if (in_field && rows_q[i][row]) begin
          pos_data_d = BLOCK_COLOR;
        end else if (in_hit) begin
          pos_data_d = note[i] ? HIT_ON_COLOR : HIT_OFF_COLOR;
        end
      end
    end
  end

  // Bottom row of every lane feeds the scoring logic directly.
  always_comb begin
    hit_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_lanes[i] = rows_q[i][ROWS-1];
    end
  end

  // State and registered pixel output.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      step_q     <= 1'b0;
      cap_q      <= '0;
      rows_q     <= '0;
      pos_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      cap_q      <= cap_d;
      rows_q     <= rows_d;
      pos_data_q <= pos_data_d;
    end
  end

  assign pos_data = pos_data_q;
  assign step     = step_q;

endmodule

// File: tb/tb_note_lane_vga.sv
// Directed bench for note_lane_vga with PERIOD=4, other parameters default.
module tb_note_lane_vga;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pos_x, pos_y;
  logic [6:0]  note;
  logic [1:0]  shift;
  logic        pause, clear;
  logic [23:0] pos_data;
  logic        step;
  logic [6:0]  hit_lanes;

  int n_cmp = 0;
  int n_bad = 0;

  note_lane_vga #(.PERIOD(4)) dut (
    .vga_clk  (clk),
    .rst      (rst),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .note     (note),
    .shift    (shift),
    .pause    (pause),
    .clear    (clear),
    .pos_data (pos_data),
    .step     (step),
    .hit_lanes(hit_lanes)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the next step pulse, bounded.
  task automatic wait_step(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (step === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: step not seen within 8 cycles (got 0, want 1)", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pos_x = 10'd0; pos_y = 10'd0; note = '0; shift = 2'b11;
    pause = 1'b0; clear = 1'b0;
    tick(); tick();
    n_cmp++; if (pos_data !== 24'h0) begin n_bad++; $display("FAIL rst_pos_data: got %h want 000000", pos_data); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL rst_step: got %b want 0", step); end
    n_cmp++; if (hit_lanes !== 7'h0) begin n_bad++; $display("FAIL rst_hit_lanes: got %h want 00", hit_lanes); end
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++;
      if (step !== (e == 4)) begin n_bad++; $display("FAIL first_step edge%0d: got %b want %b", e, step, (e == 4)); end
    end
    tick(); tick();
    n_cmp++; if (pos_data !== 24'hFFFFFF) begin n_bad++; $display("FAIL pre_reset_pix: got %h want FFFFFF", pos_data); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pos_data !== 24'h0) begin n_bad++; $display("FAIL async_pos_data: got %h want 000000", pos_data); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL async_step: got %b want 0", step); end
    n_cmp++; if (hit_lanes !== 7'h0) begin n_bad++; $display("FAIL async_hit: got %h want 00", hit_lanes); end
    tick(); tick();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++;
      if (step !== (e == 4)) begin n_bad++; $display("FAIL rerelease_step edge%0d: got %b want %b", e, step, (e == 4)); end
    end
  endtask

  task automatic test_short_press();
    shift = 2'b10;
    tick();
    note = 7'b0000001;
    tick();
    note = '0;
    wait_step("short_press_load");
    pos_x = 10'd112; pos_y = 10'd0;
    tick();
    n_cmp++; if (pos_data !== 24'h000000) begin n_bad++; $display("FAIL press_cell_112: got %h want 000000", pos_data); end
    pos_x = 10'd111;
    tick();
    n_cmp++; if (pos_data !== 24'h0000FF) begin n_bad++; $display("FAIL press_bg_111: got %h want 0000FF", pos_data); end
    for (int s = 2; s <= 97; s++) begin
      wait_step("scroll");
      if (s == 95) begin
        n_cmp++; if (hit_lanes !== 7'h00) begin n_bad++; $display("FAIL hit_step95: got %h want 00", hit_lanes); end
      end
      if (s == 96) begin
        n_cmp++; if (hit_lanes !== 7'h01) begin n_bad++; $display("FAIL hit_step96: got %h want 01", hit_lanes); end
      end
      if (s == 97) begin
        n_cmp++; if (hit_lanes !== 7'h00) begin n_bad++; $display("FAIL hit_step97: got %h want 00", hit_lanes); end
      end
    end
  endtask

  task automatic test_pause();
    bit stepped;
    stepped = 1'b0;
    tick();
    pause = 1'b1;
    for (int c = 0; c < 50; c++) begin
      note = (c == 10 || c == 30) ? 7'b0001000 : 7'b0;
      tick();
      if (step !== 1'b0) stepped = 1'b1;
    end
    note = '0;
    n_cmp++; if (stepped) begin n_bad++; $display("FAIL pause_step: got 1 want 0"); end
    pause = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (step !== (e == 3)) begin n_bad++; $display("FAIL unpause_step edge%0d: got %b want %b", e, step, (e == 3)); end
    end
    pos_x = 10'd304; pos_y = 10'd0;
    tick();
    n_cmp++; if (pos_data !== 24'h000000) begin n_bad++; $display("FAIL pause_lane3_row0: got %h want 000000", pos_data); end
  endtask

  task automatic test_clear_vs_step();
    note = 7'b0000100;
    tick();
    note = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL clear_step: got %b want 0", step); end
    n_cmp++; if (hit_lanes !== 7'h0) begin n_bad++; $display("FAIL clear_hit: got %h want 00", hit_lanes); end
    n_cmp++; if (pos_data !== 24'h000000) begin n_bad++; $display("FAIL clear_edge_pix: got %h want 000000", pos_data); end
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) begin
        n_cmp++; if (pos_data !== 24'h0000FF) begin n_bad++; $display("FAIL clear_lane3: got %h want 0000FF", pos_data); end
      end
      n_cmp++;
      if (step !== (e == 4)) begin n_bad++; $display("FAIL post_clear_step edge%0d: got %b want %b", e, step, (e == 4)); end
    end
    pos_x = 10'd240;
    tick();
    n_cmp++; if (pos_data !== 24'h0000FF) begin n_bad++; $display("FAIL clear_cap_lane2: got %h want 0000FF", pos_data); end
  endtask

  task automatic test_colour_map();
    pos_x = 10'd0; pos_y = 10'd200; shift = 2'b10;
    tick();
    n_cmp++; if (pos_data !== 24'h6464FF) begin n_bad++; $display("FAIL bg_high: got %h want 6464FF", pos_data); end
    shift = 2'b01;
    tick();
    n_cmp++; if (pos_data !== 24'hFF6464) begin n_bad++; $display("FAIL bg_low: got %h want FF6464", pos_data); end
    shift = 2'b11;
    tick();
    n_cmp++; if (pos_data !== 24'hFFFFFF) begin n_bad++; $display("FAIL bg_mid: got %h want FFFFFF", pos_data); end
    pos_x = 10'd176; pos_y = 10'd405; shift = 2'b00; note = '0;
    tick();
    n_cmp++; if (pos_data !== 24'h808080) begin n_bad++; $display("FAIL hitbar_off: got %h want 808080", pos_data); end
    note = 7'b0000010;
    tick();
    n_cmp++; if (pos_data !== 24'hFFD700) begin n_bad++; $display("FAIL hitbar_on: got %h want FFD700", pos_data); end
    note = '0;
  endtask

  task automatic test_lane_edges();
    note = 7'b0000011;
    tick();
    note = '0;
    wait_step("edges_load");
    shift = 2'b10; pos_y = 10'd0;
    pos_x = 10'd143;
    tick();
    n_cmp++; if (pos_data !== 24'h000000) begin n_bad++; $display("FAIL edge_x143: got %h want 000000", pos_data); end
    pos_x = 10'd144;
    tick();
    n_cmp++; if (pos_data !== 24'h0000FF) begin n_bad++; $display("FAIL edge_x144: got %h want 0000FF", pos_data); end
    pos_x = 10'd175;
    tick();
    n_cmp++; if (pos_data !== 24'h0000FF) begin n_bad++; $display("FAIL edge_x175: got %h want 0000FF", pos_data); end
    pos_x = 10'd176;
    tick();
    n_cmp++; if (pos_data !== 24'h000000) begin n_bad++; $display("FAIL edge_x176: got %h want 000000", pos_data); end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_pause();
    test_clear_vs_step();
    test_colour_map();
    test_lane_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
